// File: rtl/mux_logic_unit_pipe.sv
// mux_logic_unit_pipe: two-stage bitwise logic unit built from per-bit 4:1 mux
// slices. The opcode resolves to a 4-bit truth table that feeds every slice,
// and the operand bits {y[i], x[i]} select one entry per bit.
// Valid/ready handshake on both sides; counts completed output handshakes.
module mux_logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_lut,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero,
    output logic [CW-1:0]    op_count
);

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_NAND   = 3'd1,
        OP_OR     = 3'd2,
        OP_NOR    = 3'd3,
        OP_XOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOTX   = 3'd6,
        OP_CUSTOM = 3'd7
    } op_e;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;
    logic [3:0]       s1_t_q, s1_t_d;

    // Stage 2 registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             zero_q, zero_d;

    // Custom truth table and handshake counter
    logic [3:0]       cfg_q, cfg_d;
    logic [CW-1:0]    count_q, count_d;

    // Handshake / advance terms
    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic [3:0]       t_sel;
    logic [WIDTH-1:0] slice_out;

    // Pipeline advance rules; in_ready is independent of in_valid
    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s2_free;
        accept   = in_valid && in_ready;
    end

    // Opcode to truth-table resolution; CUSTOM reads the pre-edge register
    always_comb begin
        t_sel = 4'b0000;
        case (op_e'(op))
            OP_AND:    t_sel = 4'b1000;
            OP_NAND:   t_sel = 4'b0111;
            OP_OR:     t_sel = 4'b1110;
            OP_NOR:    t_sel = 4'b0001;
            OP_XOR:    t_sel = 4'b0110;
            OP_XNOR:   t_sel = 4'b1001;
            OP_NOTX:   t_sel = 4'b0101;
            OP_CUSTOM: t_sel = cfg_q;
            default:   t_sel = 4'b0000;
        endcase
    end

    // Per-bit 4:1 mux slices evaluated from the stage-1 contents
    always_comb begin
        slice_out = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            slice_out[i] = s1_t_q[{s1_y_q[i], s1_x_q[i]}];
        end
    end

    // Next-state for both stages, the custom table and the counter
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_y_d      = s1_y_q;
        s1_t_d      = s1_t_q;
        out_valid_d = out_valid_q;
        f_d         = f_q;
        zero_d      = zero_q;
        cfg_d       = cfg_q;
        count_d     = count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_x_d     = x;
            s1_y_d     = y;
            s1_t_d     = t_sel;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            out_valid_d = 1'b1;
            f_d         = slice_out;
            zero_d      = (slice_out == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (cfg_we) begin
            cfg_d = cfg_lut;
        end

        if (out_valid_q && out_ready) begin
            count_d = count_q + CW'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_t_q      <= 4'b0000;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            zero_q      <= 1'b1;
            cfg_q       <= 4'b0000;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_t_q      <= s1_t_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            zero_q      <= zero_d;
            cfg_q       <= cfg_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign zero      = zero_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_mux_logic_unit_pipe.sv
// Scoreboard bench for mux_logic_unit_pipe: the driver pushes hand-computed
// results on acceptance, a monitor pops and compares on each output handshake.
module tb_mux_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] op;
    logic       cfg_we;
    logic [3:0] cfg_lut;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] f;
    logic       zero;
    logic [15:0] op_count;

    // Second instance with a 2-bit counter, sharing all inputs, for wrap checks
    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] f2;
    logic       zero2;
    logic [1:0] op_count2;

    typedef struct {
        logic [7:0] f;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    always #5 clk = ~clk;

    mux_logic_unit_pipe #(.WIDTH(8), .CW(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .cfg_we(cfg_we), .cfg_lut(cfg_lut),
        .out_valid(out_valid), .out_ready(out_ready), .f(f), .zero(zero),
        .op_count(op_count)
    );

    mux_logic_unit_pipe #(.WIDTH(8), .CW(2)) u_dut_cw2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .x(x), .y(y), .op(op), .cfg_we(cfg_we), .cfg_lut(cfg_lut),
        .out_valid(out_valid2), .out_ready(out_ready), .f(f2), .zero(zero2),
        .op_count(op_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare result and counter at every negedge outside reset
    always @(negedge clk) begin
        if (reset_n) begin
            chk("op_count", 32'(op_count), 32'(hs_cnt[15:0]));
            chk("op_count_cw2", 32'(op_count2), 32'(hs_cnt[1:0]));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got f=%0h, expected no output", f);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_f", 32'(f), 32'(e.f));
                    chk("result_zero", 32'(zero), 32'(e.z));
                end
                hs_cnt++;
            end
        end
    end

    // Present one transaction; called just after a rising edge
    task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ef, input logic ez,
                        input logic we = 1'b0, input logic [3:0] lut = 4'b0000);
        bit ok;
        in_valid = 1'b1;
        op       = o;
        x        = a;
        y        = b;
        cfg_we   = we;
        cfg_lut  = lut;
        ok       = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                e.f = ef;
                e.z = ez;
                exp_q.push_back(e);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, expected acceptance within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    // Wait until every expected result has been consumed
    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_f"}, 32'(f), 32'h00);
        chk({tag, "_zero"}, 32'(zero), 32'd1);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        x         = 8'h00;
        y         = 8'h00;
        op        = 3'd0;
        cfg_we    = 1'b0;
        cfg_lut   = 4'b0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Opcode sweep, back-to-back with out_ready high
        send(3'd0, 8'hC5, 8'hA3, 8'h81, 1'b0);
        send(3'd1, 8'hC5, 8'hA3, 8'h7E, 1'b0);
        send(3'd2, 8'hC5, 8'hA3, 8'hE7, 1'b0);
        send(3'd3, 8'hC5, 8'hA3, 8'h18, 1'b0);
        send(3'd4, 8'hC5, 8'hA3, 8'h66, 1'b0);
        send(3'd5, 8'hC5, 8'hA3, 8'h99, 1'b0);
        send(3'd6, 8'hC5, 8'hA3, 8'h3A, 1'b0);
        drain();
        chk("sweep_op_count", 32'(op_count), 32'd7);

        // Custom table: write coincides with acceptance, old table applies
        send(3'd7, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b1, 4'b0010);
        send(3'd7, 8'hF0, 8'h0F, 8'hF0, 1'b0);
        drain();

        // Zero flag
        send(3'd0, 8'h55, 8'hAA, 8'h00, 1'b1);
        send(3'd2, 8'h55, 8'hAA, 8'hFF, 1'b0);
        drain();

        // Backpressure: two accepted, third blocked, output held
        out_ready = 1'b0;
        send(3'd0, 8'hFF, 8'h0F, 8'h0F, 1'b0);
        send(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
        in_valid = 1'b1;
        op       = 3'd0;
        x        = 8'hAA;
        y        = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_f", 32'(f), 32'h0F);
            op = 3'(i + 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'd0, 8'hAA, 8'hFF, 8'hAA, 1'b0);
        drain();

        // Reset with both stages full, then a fresh transaction
        out_ready = 1'b0;
        send(3'd2, 8'h12, 8'h34, 8'h36, 1'b0);
        send(3'd4, 8'h0F, 8'hFF, 8'hF0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        exp_q.delete();
        hs_cnt = 0;
        #1;
        check_reset_state("midreset");
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(3'd5, 8'h3C, 8'h0F, 8'hCC, 1'b0);
        @(negedge clk);
        chk("latency_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_f", 32'(f), 32'hCC);
        drain();
        chk("final_op_count", 32'(op_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
